// File: rtl/ethernet_tx_dma_pkg.sv
// Shared types and MMIO map for the ethernet TX DMA master.
// Addresses match the ethernet controller's slave decoder.
package ethernet_tx_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POLL_REQ,
    POLL_RESP,
    STREAM,
    DRAIN,
    SIZE,
    SEND,
    CLEAR
  } state_e;

  localparam logic [1:0] op_size_word_c = 2'b10;

  localparam int eth_mtu_c           = 2048;
  localparam int tx_buf_base_c       = 'h1000;
  localparam int tx_size_addr_c      = 'h0828;
  localparam int tx_send_addr_c      = 'h0830;
  localparam int tx_status_addr_c    = 'h0838;
  localparam int tx_irq_clear_addr_c = 'h0840;

endpackage

// File: rtl/ethernet_tx_dma.sv
// Streams frames into the ethernet TX buffer over MMIO.
// Define ETHERNET_TX_DMA_IRQ_WAIT_EN to gate on TX irq instead of polling.
module ethernet_tx_dma
  import ethernet_tx_dma_pkg::*;
#(
  parameter int data_width_p        = 32,
  parameter int eth_mtu_p           = eth_mtu_c,
  parameter int addr_width_p        = 14,
  parameter int tx_buf_base_p       = tx_buf_base_c,
  parameter int tx_size_addr_p      = tx_size_addr_c,
  parameter int tx_send_addr_p      = tx_send_addr_c,
  parameter int tx_status_addr_p    = tx_status_addr_c,
  parameter int tx_irq_clear_addr_p = tx_irq_clear_addr_c,
  parameter int count_width_p       = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [data_width_p-1:0]  data_i,
  input  logic                     v_i,
  input  logic                     last_i,
  input  logic [1:0]               last_bytes_i,
  output logic                     ready_and_o,
  output logic [addr_width_p-1:0]  addr_o,
  output logic                     write_en_o,
  output logic                     read_en_o,
  output logic [1:0]               op_size_o,
  output logic [data_width_p-1:0]  write_data_o,
  input  logic [data_width_p-1:0]  read_data_i,
  input  logic                     tx_interrupt_pending_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     drop_o,
  output logic [count_width_p-1:0] sent_count_o,
  output logic [count_width_p-1:0] drop_count_o
);

  localparam int cnt_w_lp = $clog2(eth_mtu_p + 1);

  state_e                   state_q;
  logic [cnt_w_lp-1:0]      byte_cnt_q;
  logic [cnt_w_lp-1:0]      inc;
  logic                     full;
  logic                     done_q;
  logic                     drop_q;
  logic [count_width_p-1:0] sent_q;
  logic [count_width_p-1:0] drop_cnt_q;
  logic                     unused_in;

`ifdef ETHERNET_TX_DMA_IRQ_WAIT_EN
  logic first_q;
  assign unused_in = ^read_data_i;
`else
  assign unused_in = ^{read_data_i[data_width_p-1:1],
                       tx_interrupt_pending_i};
`endif

  assign full = (byte_cnt_q == cnt_w_lp'(eth_mtu_p));
  assign inc  = (last_i && last_bytes_i != 2'd0)
              ? cnt_w_lp'(last_bytes_i)
              : cnt_w_lp'(4);

  assign ready_and_o  = (state_q == STREAM) || (state_q == DRAIN);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign drop_o       = drop_q;
  assign sent_count_o = sent_q;
  assign drop_count_o = drop_cnt_q;

  // MMIO strobes, address and data decoded from state and handshake
  always_comb begin
    read_en_o    = 1'b0;
    write_en_o   = 1'b0;
    addr_o       = '0;
    write_data_o = '0;
    unique case (state_q)
      POLL_REQ: begin
        read_en_o = 1'b1;
        addr_o    = addr_width_p'(tx_status_addr_p);
      end
      CLEAR: begin
        write_en_o   = 1'b1;
        addr_o       = addr_width_p'(tx_irq_clear_addr_p);
        write_data_o = data_width_p'(1);
      end
      STREAM: begin
        if (v_i && !full) begin
          write_en_o   = 1'b1;
          addr_o       = addr_width_p'(tx_buf_base_p)
                       + addr_width_p'(byte_cnt_q);
          write_data_o = data_i;
        end
      end
      SIZE: begin
        write_en_o   = 1'b1;
        addr_o       = addr_width_p'(tx_size_addr_p);
        write_data_o = data_width_p'(byte_cnt_q);
      end
      SEND: begin
        write_en_o   = 1'b1;
        addr_o       = addr_width_p'(tx_send_addr_p);
        write_data_o = data_width_p'(1);
      end
      default: ;
    endcase
    op_size_o = (read_en_o || write_en_o) ? op_size_word_c : 2'b00;
  end

  // Transmit sequencer with byte counter and sent/drop counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      done_q     <= 1'b0;
      drop_q     <= 1'b0;
      sent_q     <= '0;
      drop_cnt_q <= '0;
`ifdef ETHERNET_TX_DMA_IRQ_WAIT_EN
      first_q    <= 1'b1;
`endif
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (v_i) state_q <= POLL_REQ;
        end
`ifdef ETHERNET_TX_DMA_IRQ_WAIT_EN
        POLL_REQ: begin
          if (first_q || tx_interrupt_pending_i) begin
            first_q <= 1'b0;
            state_q <= CLEAR;
          end
        end
        CLEAR: state_q <= STREAM;
`else
        POLL_REQ: state_q <= POLL_RESP;
        POLL_RESP: begin
          state_q <= read_data_i[0] ? STREAM : POLL_REQ;
        end
`endif
        STREAM: begin
          if (v_i) begin
            if (full) begin
              if (last_i) begin
                drop_q     <= 1'b1;
                drop_cnt_q <= drop_cnt_q + count_width_p'(1);
                byte_cnt_q <= '0;
                state_q    <= IDLE;
              end else begin
                state_q <= DRAIN;
              end
            end else begin
              byte_cnt_q <= byte_cnt_q + inc;
              if (last_i) state_q <= SIZE;
            end
          end
        end
        DRAIN: begin
          if (v_i && last_i) begin
            drop_q     <= 1'b1;
            drop_cnt_q <= drop_cnt_q + count_width_p'(1);
            byte_cnt_q <= '0;
            state_q    <= IDLE;
          end
        end
        SIZE: begin
          done_q  <= 1'b1;
          state_q <= SEND;
        end
        SEND: begin
          sent_q     <= sent_q + count_width_p'(1);
          byte_cnt_q <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ethernet_tx_dma.sv
// Directed bench for ethernet_tx_dma (status-polling build).
// Bench acts as MMIO slave and packet source, logs every MMIO op.
module tb_ethernet_tx_dma;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] data_i;
  logic        v_i;
  logic        last_i;
  logic [1:0]  last_bytes_i;
  logic        ready_and_o;
  logic [13:0] addr_o;
  logic        write_en_o;
  logic        read_en_o;
  logic [1:0]  op_size_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i;
  logic        tx_interrupt_pending_i;
  logic        busy_o;
  logic        done_o;
  logic        drop_o;
  logic [15:0] sent_count_o;
  logic [15:0] drop_count_o;

  ethernet_tx_dma dut (
    .clk_i                  (clk_i),
    .reset_n_i              (reset_n_i),
    .data_i                 (data_i),
    .v_i                    (v_i),
    .last_i                 (last_i),
    .last_bytes_i           (last_bytes_i),
    .ready_and_o            (ready_and_o),
    .addr_o                 (addr_o),
    .write_en_o             (write_en_o),
    .read_en_o              (read_en_o),
    .op_size_o              (op_size_o),
    .write_data_o           (write_data_o),
    .read_data_i            (read_data_i),
    .tx_interrupt_pending_i (tx_interrupt_pending_i),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .drop_o                 (drop_o),
    .sent_count_o           (sent_count_o),
    .drop_count_o           (drop_count_o)
  );

  always #5 clk_i = ~clk_i;

  int          vecs = 0;
  int          errs = 0;
  logic [13:0] wa[$];
  logic [31:0] wd[$];
  int          st_q[$];
  int          n_reads, n_done, n_drop, n_ops, n_badsz, n_both;
  bit          rd_pend, rsp, last_hs;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); st_q.delete();
    n_reads = 0; n_done = 0; n_drop = 0;
    n_ops = 0; n_badsz = 0; n_both = 0;
  endtask

  // observe one cycle at negedge+1, then advance to next negedge
  task automatic step();
    #1;
    last_hs = v_i && ready_and_o;
    if (write_en_o && read_en_o) n_both++;
    if ((write_en_o || read_en_o) && op_size_o != 2'b10) n_badsz++;
    if (write_en_o || read_en_o) n_ops++;
    if (write_en_o) begin
      wa.push_back(addr_o);
      wd.push_back(write_data_o);
    end
    if (read_en_o) begin
      n_reads++;
      rsp = (st_q.size() > 0) ? st_q.pop_front() != 0 : 1'b1;
      rd_pend = 1'b1;
    end
    if (done_o) n_done++;
    if (drop_o) n_drop++;
    @(posedge clk_i);
    @(negedge clk_i);
    read_data_i = rd_pend ? {31'b0, rsp} : 32'h0;
    rd_pend = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] d, input bit last,
                          input logic [1:0] lb);
    int budget;
    budget = 0;
    v_i = 1'b1; data_i = d; last_i = last; last_bytes_i = lb;
    do begin
      step();
      budget++;
    end while (!last_hs && budget < 200);
    if (!last_hs) chk("hs_timeout", 0, 1);
    v_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (busy_o && budget < 200) begin
      step();
      budget++;
    end
    if (busy_o) chk("idle_timeout", 1, 0);
    repeat (3) step();
  endtask

  task automatic frame(input int nw, input logic [1:0] lb,
                       input int gap_after, input int gap_len);
    for (int i = 0; i < nw; i++) begin
      put_word(32'hA500_0000 + i, i == nw - 1, lb);
      if (i == gap_after) begin
        int o0;
        o0 = n_ops;
        repeat (gap_len) step();
        chk("gap_ops", n_ops - o0, 0);
      end
    end
    wait_idle();
  endtask

  task automatic chk_buf(input string tag, input int nw);
    int bad;
    bad = 0;
    for (int i = 0; i < nw; i++) begin
      if (wa[i] != 14'h1000 + 14'(4 * i)) bad++;
      if (wd[i] != 32'hA500_0000 + i) bad++;
    end
    chk(tag, bad, 0);
  endtask

  initial begin
    reset_n_i = 1'b0; data_i = '0; v_i = 1'b0; last_i = 1'b0;
    last_bytes_i = 2'd0; read_data_i = '0;
    tx_interrupt_pending_i = 1'b0;
    rd_pend = 1'b0; rsp = 1'b0; last_hs = 1'b0;
    clr();
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_ready", ready_and_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_wr", write_en_o, 0);
    chk("rst_rd", read_en_o, 0);
    chk("rst_sent", sent_count_o, 0);
    chk("rst_drop", drop_count_o, 0);
    @(negedge clk_i);
    reset_n_i = 1'b1;

    // 3-word frame after two busy status reads
    clr();
    st_q.push_back(0); st_q.push_back(0); st_q.push_back(1);
    frame(3, 2'd2, -1, 0);
    chk("f1_reads", n_reads, 3);
    chk("f1_nwr", wa.size(), 5);
    if (wa.size() == 5) begin
      chk_buf("f1_buf", 3);
      chk("f1_size_a", wa[3], 14'h0828);
      chk("f1_size_d", wd[3], 10);
      chk("f1_send_a", wa[4], 14'h0830);
      chk("f1_send_d", wd[4], 1);
    end
    chk("f1_done", n_done, 1);
    chk("f1_sent", sent_count_o, 1);

    // maximum legal frame: 512 words, 2048 bytes
    clr();
    frame(512, 2'd0, -1, 0);
    chk("f2_nwr", wa.size(), 514);
    if (wa.size() == 514) begin
      chk_buf("f2_buf", 512);
      chk("f2_size_a", wa[512], 14'h0828);
      chk("f2_size_d", wd[512], 2048);
      chk("f2_send_a", wa[513], 14'h0830);
    end
    chk("f2_drop", n_drop, 0);
    chk("f2_sent", sent_count_o, 2);

    // 513 words: overflow word is last, frame discarded
    clr();
    frame(513, 2'd0, -1, 0);
    chk("f3_nwr", wa.size(), 512);
    if (wa.size() == 512) chk_buf("f3_buf", 512);
    chk("f3_drop_pulse", n_drop, 1);
    chk("f3_dropcnt", drop_count_o, 1);
    chk("f3_sent", sent_count_o, 2);
    chk("f3_busy", busy_o, 0);

    // 514 words: overflow mid-frame drains to last
    clr();
    frame(514, 2'd0, -1, 0);
    chk("f4_nwr", wa.size(), 512);
    chk("f4_dropcnt", drop_count_o, 2);
    chk("f4_done", n_done, 0);

    // source stall after word 1
    clr();
    frame(4, 2'd0, 1, 5);
    chk("f5_nwr", wa.size(), 6);
    if (wa.size() == 6) begin
      chk_buf("f5_buf", 4);
      chk("f5_size_d", wd[4], 16);
    end
    chk("f5_sent", sent_count_o, 3);

    // reset during word 2 of 4
    clr();
    put_word(32'hA500_0000, 1'b0, 2'd0);
    put_word(32'hA500_0001, 1'b0, 2'd0);
    v_i = 1'b1; data_i = 32'hA500_0002;
    reset_n_i = 1'b0;
    #1;
    chk("mrst_ready", ready_and_o, 0);
    chk("mrst_wr", write_en_o, 0);
    chk("mrst_addr", addr_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_sent", sent_count_o, 0);
    chk("mrst_drop", drop_count_o, 0);
    v_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    chk("mrst_nosend", wa.size(), 2);
    clr();
    frame(2, 2'd0, -1, 0);
    chk("f6_nwr", wa.size(), 4);
    if (wa.size() == 4) begin
      chk_buf("f6_buf", 2);
      chk("f6_size_d", wd[2], 8);
    end
    chk("f6_sent", sent_count_o, 1);

    chk("op_size", n_badsz, 0);
    chk("one_strobe", n_both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
